spi_pattern_checker: RTL
========================

Name: spi_pattern_checker

Overview:
- Parametrised SPI slave test endpoint for the FPGA side of the real-time SPI link.
- Debounces SCK/SSEL and supports all four SPI modes with configurable word width.
- Returns a deterministic incrementing pattern on MISO and checks the MOSI stream against an expected incrementing pattern.
- Exposes word/error counters and sticky flags for LEDs or a logic analyser, so host-side latency and integrity tests run unattended.

Parameters:
DEB_LEN, 10, debounce pipe length in clk cycles (>=3)
WORD_W, 8, bits per SPI word (4..32)
CPOL, 0, SCK idle level
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
TX_SEED, 8'h61, first word returned on MISO (WORD_W wide)
RX_SEED, 8'h00, first word expected on MOSI (WORD_W wide)
CNT_W, 16, width of word and error counters

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
sck  in  1  raw SPI clock from master
ssel  in  1  raw active-low slave select
mosi  in  1  raw master data
miso  out  1  slave data
clr  in  1  synchronous clear of counters, index and sticky flags
word_valid  out  1  one-cycle pulse when a word completes
rx_word  out  WORD_W  last received word
word_cnt  out  CNT_W  completed words since reset/clr (wraps)
err_cnt  out  CNT_W  mismatching words (saturates at all-ones)
err_flag  out  1  sticky: any mismatch
short_frame  out  1  sticky: SSEL deasserted mid-word
frame_active  out  1  debounced SSEL asserted

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- Reset values:
  - miso=0, word_valid=0, rx_word=0, counters=0, flags=0, frame_active=0.
  - Debounced sck=CPOL; debounced ssel=1; pipes filled with the same levels.
- Debounce (per input):
  - DEB_LEN-bit shift pipe.
  - Output goes 1 when pipe[DEB_LEN-1:1] is all ones, goes 0 when all zeros, otherwise holds.
- mosi passes through a plain DEB_LEN-stage delay line, so it stays aligned with debounced sck.
- Edge detect:
  - Register the previous debounced sck.
  - Leading edge = transition away from CPOL; trailing edge = transition back to CPOL.
  - Sample edge = leading if CPHA=0, else trailing. Shift edge = the other one.
  - Edges are ignored while ssel_deb=1.
- Frame start (ssel_deb 1->0):
  - bit_cnt=0, pend=0.
  - tx_sr loads TX_SEED+idx (mod 2^WORD_W).
  - frame_active=1 from the next cycle.
- Sample edge:
  - rx_sr={rx_sr[WORD_W-2:0], mosi_dly}, bit_cnt++, pend=1.
- Shift edge:
  - If pend=1: tx_sr shifts left one bit and pend=0.
  - If pend=0 (shift edge before the first sample of a word): no shift.
- miso = tx_sr[WORD_W-1] while ssel_deb=0, else 0.
- Word complete (sample edge with bit_cnt==WORD_W-1), registered outputs in the next cycle:
  - word_valid=1 for exactly one cycle; rx_word = completed word.
  - If the word != RX_SEED+idx: err_cnt++ (saturating) and err_flag=1.
  - word_cnt++ (wraps); idx++ (wraps at 2^WORD_W).
  - bit_cnt=0, pend=0, tx_sr reloads TX_SEED+idx_new.
  - The shift edge that follows is suppressed, so the next MSB is already presented.
- idx persists across frames; only rst/clr zero it.
- SSEL rise mid-word (bit_cnt!=0): discard the partial word, set short_frame, no word_valid, bit_cnt=0, idx unchanged.
- SSEL rise at bit_cnt==0: clean end, no flags.
- clr coinciding with word completion:
  - clr wins: counters, idx and flags end at 0.
  - word_valid and rx_word still update.
- Only asynchronous rst returns debounce pipes to idle; mid-frame rst aborts everything immediately.
- Latency from raw sck sample edge to word_valid: DEB_LEN+2 clk cycles.

Decomposition:
- Package spi_chk_pkg holds:
  - localparam mode encodings (MODE0..MODE3 = {CPOL,CPHA});
  - function next_pattern(seed, idx, width);
  - counter saturation helper.
- Sub-module spi_debounce:
  - parameters DEB_LEN and INIT;
  - ports clk, rst, din, dout;
  - instantiated for sck (INIT=CPOL) and ssel (INIT=1).

Test Plan:
- Mode 0, WORD_W=8, master sends 0x00,0x01,0x02 in one frame -> miso returns 0x61,0x62,0x63; word_cnt=3, err_cnt=0, three word_valid pulses.
- Mode 3, second word sent as 0x05 instead of 0x01 -> err_cnt=1, err_flag=1, rx_word=0x05; third word 0x02 counts no error.
- SSEL released after 5 bits -> short_frame=1, word_cnt unchanged; next frame expects the same idx (miso=0x61).
- 3-cycle glitches on sck and ssel with DEB_LEN=10 -> no bit sampled, bit_cnt and outputs unchanged.
- CNT_W=4, 20 bad words -> err_cnt saturates at 15; word_cnt wraps to 4.
- clr asserted on the word-completion cycle -> word_cnt=0, err_cnt=0, word_valid still pulses; async rst mid-word -> all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/spi_chk_pkg.sv
// Shared encodings and arithmetic helpers for the SPI pattern checker.
// The helpers work on 32-bit values masked down to the requested width.
package spi_chk_pkg;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic logic [31:0] width_mask(input int unsigned width);
    return (width >= 32) ? 32'hffff_ffff : ((32'd1 << width) - 32'd1);
  endfunction

  function automatic logic [31:0] next_pattern(input logic [31:0] seed, input logic [31:0] idx,
                                               input int unsigned width);
    return (seed + idx) & width_mask(width);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    return (val == width_mask(width)) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/spi_debounce.sv
// Level debouncer: the output flips only once the older DEB_LEN-1 pipe taps all agree.
// Both the pipe and the output start at INIT so no spurious edge follows reset.
module spi_debounce #(
  parameter int unsigned DEB_LEN = 10,
  parameter logic        INIT    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [DEB_LEN-1:0] pipe_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q <= {DEB_LEN{INIT}};
      dout   <= INIT;
    end else begin
      pipe_q <= {pipe_q[DEB_LEN-2:0], din};
      if (&pipe_q[DEB_LEN-1:1]) begin
        dout <= 1'b1;
      end else if (~|pipe_q[DEB_LEN-1:1]) begin
        dout <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spi_pattern_checker.sv
// SPI slave test endpoint: answers with an incrementing pattern on MISO and checks MOSI
// against an expected incrementing pattern, exposing counters and sticky flags.
module spi_pattern_checker
  import spi_chk_pkg::*;
#(
  parameter int unsigned       DEB_LEN = 10,
  parameter int unsigned       WORD_W  = 8,
  parameter logic              CPOL    = 1'b0,
  parameter logic              CPHA    = 1'b0,
  parameter logic [WORD_W-1:0] TX_SEED = 8'h61,
  parameter logic [WORD_W-1:0] RX_SEED = 8'h00,
  parameter int unsigned       CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              ssel,
  input  logic              mosi,
  output logic              miso,
  input  logic              clr,
  output logic              word_valid,
  output logic [WORD_W-1:0] rx_word,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_flag,
  output logic              short_frame,
  output logic              frame_active
);

  localparam int unsigned BCW         = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [1:0]  MODE        = {CPOL, CPHA};
  localparam bit          SAMPLE_LEAD = (MODE == MODE0) || (MODE == MODE2);

  logic               sck_deb, ssel_deb;
  logic               sck_prev_q, ssel_prev_q;
  logic [DEB_LEN-1:0] mosi_pipe_q;
  logic [WORD_W-1:0]  tx_sr_q, rx_sr_q, idx_q;
  logic [BCW-1:0]     bit_cnt_q;
  logic               pend_q;

  logic               lead_edge, trail_edge, sample_edge, shift_edge;
  logic               frame_start, frame_end, word_done;
  logic [WORD_W-1:0]  rx_next, rx_exp, idx_after, tx_cur, tx_after;

  spi_debounce #(
    .DEB_LEN (DEB_LEN),
    .INIT    (CPOL)
  ) u_deb_sck (
    .clk  (clk),
    .rst  (rst),
    .din  (sck),
    .dout (sck_deb)
  );

  spi_debounce #(
    .DEB_LEN (DEB_LEN),
    .INIT    (1'b1)
  ) u_deb_ssel (
    .clk  (clk),
    .rst  (rst),
    .din  (ssel),
    .dout (ssel_deb)
  );

  always_comb begin
    lead_edge   = (sck_prev_q == CPOL) && (sck_deb != CPOL);
    trail_edge  = (sck_prev_q != CPOL) && (sck_deb == CPOL);
    sample_edge = !ssel_deb && (SAMPLE_LEAD ? lead_edge : trail_edge);
    shift_edge  = !ssel_deb && (SAMPLE_LEAD ? trail_edge : lead_edge);
    frame_start = ssel_prev_q && !ssel_deb;
    frame_end   = !ssel_prev_q && ssel_deb;
    word_done   = sample_edge && (bit_cnt_q == BCW'(WORD_W - 1));
    rx_next     = {rx_sr_q[WORD_W-2:0], mosi_pipe_q[DEB_LEN-1]};
    rx_exp      = WORD_W'(next_pattern(32'(RX_SEED), 32'(idx_q), WORD_W));
    // A clear landing on word completion also restarts the MISO pattern at the seed.
    idx_after   = clr ? '0 : idx_q + WORD_W'(1);
    tx_cur      = WORD_W'(next_pattern(32'(TX_SEED), 32'(idx_q), WORD_W));
    tx_after    = WORD_W'(next_pattern(32'(TX_SEED), 32'(idx_after), WORD_W));
  end

  assign miso = !ssel_deb && tx_sr_q[WORD_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_prev_q   <= CPOL;
      ssel_prev_q  <= 1'b1;
      mosi_pipe_q  <= '0;
      tx_sr_q      <= '0;
      rx_sr_q      <= '0;
      idx_q        <= '0;
      bit_cnt_q    <= '0;
      pend_q       <= 1'b0;
      word_valid   <= 1'b0;
      rx_word      <= '0;
      word_cnt     <= '0;
      err_cnt      <= '0;
      err_flag     <= 1'b0;
      short_frame  <= 1'b0;
      frame_active <= 1'b0;
    end else begin
      sck_prev_q   <= sck_deb;
      ssel_prev_q  <= ssel_deb;
      mosi_pipe_q  <= {mosi_pipe_q[DEB_LEN-2:0], mosi};
      frame_active <= !ssel_deb;
      word_valid   <= 1'b0;

      if (frame_start) begin
        bit_cnt_q <= '0;
        pend_q    <= 1'b0;
        tx_sr_q   <= tx_cur;
      end else if (frame_end) begin
        if (bit_cnt_q != '0) short_frame <= 1'b1;
        bit_cnt_q <= '0;
        pend_q    <= 1'b0;
      end else if (word_done) begin
        word_valid <= 1'b1;
        rx_word    <= rx_next;
        rx_sr_q    <= rx_next;
        if (rx_next != rx_exp) begin
          err_cnt  <= CNT_W'(sat_inc(32'(err_cnt), CNT_W));
          err_flag <= 1'b1;
        end
        word_cnt  <= word_cnt + CNT_W'(1);
        idx_q     <= idx_q + WORD_W'(1);
        bit_cnt_q <= '0;
        // pend stays low so the next shift edge keeps the fresh MSB on the line
        pend_q    <= 1'b0;
        tx_sr_q   <= tx_after;
      end else if (sample_edge) begin
        rx_sr_q   <= rx_next;
        bit_cnt_q <= bit_cnt_q + BCW'(1);
        pend_q    <= 1'b1;
      end else if (shift_edge && pend_q) begin
        tx_sr_q <= {tx_sr_q[WORD_W-2:0], 1'b0};
        pend_q  <= 1'b0;
      end

      if (clr) begin
        word_cnt    <= '0;
        err_cnt     <= '0;
        idx_q       <= '0;
        err_flag    <= 1'b0;
        short_frame <= 1'b0;
      end
    end
  end

endmodule
